multicycle_ctrl: RTL and testbench

Main control FSM for the multi-cycle CPU. It sequences the shared datapath (PC, IR, memory port, ALU, register file) through fetch, decode, execute, memory and write-back states for a MIPS subset. It drives the register-file write enable so that exactly one write occurs per register-writing instruction. It sits beside the datapath top and is the only source of write strobes for PC, IR, memory and RF.

---
 rtl/multicycle_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS-subset CPU: sequences PC, IR, memory,
// ALU and register file through fetch/decode/execute/memory/write-back states.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_we,
    output logic       ir_we,
    output logic       i_or_d,
    output logic       mem_we,
    output logic       rf_we,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_ctrl,
    output logic [1:0] pc_src,
    output logic       illegal,
    output logic       instr_done,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_IF  = 4'd0,
        S_ID  = 4'd1,
        S_MA  = 4'd2,
        S_MR  = 4'd3,
        S_MW  = 4'd4,
        S_WM  = 4'd5,
        S_EXR = 4'd6,
        S_WR  = 4'd7,
        S_EXI = 4'd8,
        S_WI  = 4'd9,
        S_BR  = 4'd10,
        S_JMP = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    state_e     state_q;
    state_e     state_d;
    logic       funct_ok;
    logic [3:0] funct_alu;

    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = ALU_AND;
        case (funct)
            FN_ADD:  funct_alu = ALU_ADD;
            FN_SUB:  funct_alu = ALU_SUB;
            FN_AND:  funct_alu = ALU_AND;
            FN_OR:   funct_alu = ALU_OR;
            FN_SLT:  funct_alu = ALU_SLT;
            default: funct_ok  = 1'b0;
        endcase
    end

    // NOTE: state flops use non-blocking assignment so every flop samples the
    // pre-edge values of its inputs, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IF;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every comb output gets a default before the case so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d = S_IF;
        case (state_q)
            S_IF:  state_d = S_ID;
            S_ID: begin
                if (op == OP_RTYPE && funct_ok)       state_d = S_EXR;
                else if (op == OP_LW || op == OP_SW)  state_d = S_MA;
                else if (op == OP_ADDI)               state_d = S_EXI;
                else if (op == OP_BEQ)                state_d = S_BR;
                else if (op == OP_J)                  state_d = S_JMP;
                else                                  state_d = S_IF;
            end
            S_MA:  state_d = (op == OP_LW) ? S_MR : S_MW;
            S_MR:  state_d = S_WM;
            S_EXR: state_d = S_WR;
            S_EXI: state_d = S_WI;
            default: state_d = S_IF;
        endcase
    end

    always_comb begin
        pc_we      = 1'b0;
        ir_we      = 1'b0;
        i_or_d     = 1'b0;
        mem_we     = 1'b0;
        rf_we      = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_ctrl   = 4'b0000;
        pc_src     = 2'b00;
        illegal    = 1'b0;
        instr_done = 1'b0;
        // Reset shows the IF datapath selects but suppresses every strobe.
        if (rst) begin
            alu_src_b = 2'b01;
            alu_ctrl  = ALU_ADD;
        end else begin
            case (state_q)
                S_IF: begin
                    ir_we     = 1'b1;
                    pc_we     = 1'b1;
                    alu_src_b = 2'b01;
                    alu_ctrl  = ALU_ADD;
                end
                S_ID: begin
                    alu_src_b = 2'b11;
                    alu_ctrl  = ALU_ADD;
                    if (state_d == S_IF) begin
                        illegal    = 1'b1;
                        instr_done = 1'b1;
                    end
                end
                S_MA, S_EXI: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    alu_ctrl  = ALU_ADD;
                end
                S_MR: i_or_d = 1'b1;
                S_MW: begin
                    i_or_d     = 1'b1;
                    mem_we     = 1'b1;
                    instr_done = 1'b1;
                end
                S_WM: begin
                    rf_we      = 1'b1;
                    mem_to_reg = 1'b1;
                    instr_done = 1'b1;
                end
                S_EXR: begin
                    alu_src_a = 1'b1;
                    alu_ctrl  = funct_alu;
                end
                S_WR: begin
                    rf_we      = 1'b1;
                    reg_dst    = 1'b1;
                    instr_done = 1'b1;
                end
                S_WI: begin
                    rf_we      = 1'b1;
                    instr_done = 1'b1;
                end
                S_BR: begin
                    alu_src_a  = 1'b1;
                    alu_ctrl   = ALU_SUB;
                    pc_src     = 2'b01;
                    pc_we      = zero;
                    instr_done = 1'b1;
                end
                S_JMP: begin
                    pc_src     = 2'b10;
                    pc_we      = 1'b1;
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-instruction state traces, a
// state-to-output model, pulse counts per instruction and hand-pinned cycles.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic       pc_we;
        logic       ir_we;
        logic       i_or_d;
        logic       mem_we;
        logic       rf_we;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_ctrl;
        logic [1:0] pc_src;
        logic       illegal;
        logic       instr_done;
    } outs_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pc_we, ir_we, i_or_d, mem_we, rf_we, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_ctrl;
    logic [1:0] pc_src;
    logic       illegal, instr_done;
    logic [3:0] state;
    outs_t      dut_o;

    // Expectations driven by the stimulus for the current cycle.
    logic       chk_en = 1'b0;
    logic [3:0] exp_state = 4'd0;
    logic       last = 1'b0;
    logic       pin_en = 1'b0;
    outs_t      pin_v = '0;
    int         exp_rf = 0, exp_mem = 0, exp_done = 0;

    int total = 0;
    int bad   = 0;
    int rf_n = 0, mem_n = 0, done_n = 0;

    multicycle_ctrl dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
        .pc_we(pc_we), .ir_we(ir_we), .i_or_d(i_or_d), .mem_we(mem_we),
        .rf_we(rf_we), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
        .pc_src(pc_src), .illegal(illegal), .instr_done(instr_done), .state(state)
    );

    assign dut_o = {pc_we, ir_we, i_or_d, mem_we, rf_we, reg_dst, mem_to_reg,
                    alu_src_a, alu_src_b, alu_ctrl, pc_src, illegal, instr_done};

    always #5 clk = ~clk;

    function automatic logic legal_instr(input logic [5:0] o, input logic [5:0] f);
        if (o == 6'b000000)
            return f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        return o inside {6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
    endfunction

    function automatic logic [3:0] funct_to_alu(input logic [5:0] f);
        if (f == 6'b100000) return 4'b0010;
        if (f == 6'b100010) return 4'b0110;
        if (f == 6'b100100) return 4'b0000;
        if (f == 6'b100101) return 4'b0001;
        if (f == 6'b101010) return 4'b0111;
        return 4'b0000;
    endfunction

    // Outputs derived field by field from what each state is for.
    function automatic outs_t model(input logic [3:0] st_in, input logic r,
                                    input logic [5:0] o, input logic [5:0] f,
                                    input logic z);
        outs_t m;
        logic [3:0] st;
        st = r ? 4'd0 : st_in;
        m = '0;
        m.ir_we      = (st == 4'd0);
        m.pc_we      = (st == 4'd0) || (st == 4'd11) || (st == 4'd10 && z);
        m.i_or_d     = st inside {4'd3, 4'd4};
        m.mem_we     = (st == 4'd4);
        m.rf_we      = st inside {4'd5, 4'd7, 4'd9};
        m.reg_dst    = (st == 4'd7);
        m.mem_to_reg = (st == 4'd5);
        m.alu_src_a  = st inside {4'd2, 4'd6, 4'd8, 4'd10};
        m.alu_src_b  = (st == 4'd0) ? 2'b01 : (st == 4'd1) ? 2'b11 :
                       (st inside {4'd2, 4'd8}) ? 2'b10 : 2'b00;
        m.alu_ctrl   = (st inside {4'd0, 4'd1, 4'd2, 4'd8}) ? 4'b0010 :
                       (st == 4'd10) ? 4'b0110 :
                       (st == 4'd6) ? funct_to_alu(f) : 4'b0000;
        m.pc_src     = (st == 4'd10) ? 2'b01 : (st == 4'd11) ? 2'b10 : 2'b00;
        m.illegal    = (st == 4'd1) && !legal_instr(o, f);
        m.instr_done = (st inside {4'd4, 4'd5, 4'd7, 4'd9, 4'd10, 4'd11}) || m.illegal;
        if (r) begin
            m.pc_we = 1'b0; m.ir_we = 1'b0; m.mem_we = 1'b0; m.rf_we = 1'b0;
            m.illegal = 1'b0; m.instr_done = 1'b0;
        end
        return m;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Single compare process, sampling on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("state", {28'd0, state}, {28'd0, exp_state});
                check("outputs", {13'd0, dut_o}, {13'd0, model(exp_state, rst, op, funct, zero)});
                if (pin_en) check("pinned", {13'd0, dut_o}, {13'd0, pin_v});
                rf_n   += int'(rf_we);
                mem_n  += int'(mem_we);
                done_n += int'(instr_done);
                if (last) begin
                    check("rf_we_count", rf_n, exp_rf);
                    check("mem_we_count", mem_n, exp_mem);
                    check("instr_done_count", done_n, exp_done);
                    rf_n = 0; mem_n = 0; done_n = 0;
                end
            end
        end
    end

    task automatic cyc(input logic [3:0] st, input logic lst);
        exp_state = st;
        last      = lst;
        @(posedge clk);
        #1;
        pin_en = 1'b0;
    endtask

    // Trace nibbles are packed first-state-lowest.
    task automatic instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                         input logic [23:0] tr, input int n, input int rf, input int mem,
                         input int pidx, input outs_t pv);
        op = o; funct = f; zero = z;
        exp_rf = rf; exp_mem = mem; exp_done = 1;
        for (int i = 0; i < n; i++) begin
            pin_en = (i == pidx);
            pin_v  = pv;
            cyc(tr[4*i +: 4], i == n - 1);
        end
    endtask

    initial begin
        rst = 1'b1; op = 6'd0; funct = 6'd0; zero = 1'b0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        cyc(4'd0, 1'b0);
        cyc(4'd0, 1'b0);
        rst = 1'b0;

        // lw aborted by reset while in MR.
        op = 6'b100011; funct = 6'd0;
        exp_rf = 0; exp_mem = 0; exp_done = 0;
        cyc(4'd0, 1'b0);
        cyc(4'd1, 1'b0);
        cyc(4'd2, 1'b0);
        rst = 1'b1;
        cyc(4'd3, 1'b0);
        cyc(4'd0, 1'b1);
        rst = 1'b0;

        instr(6'b100011, 6'd0, 1'b0, 24'h053210, 5, 1, 0, 4,
              outs_t'{rf_we:1'b1, mem_to_reg:1'b1, instr_done:1'b1, default:'0});
        instr(6'b000000, 6'b100010, 1'b0, 24'h007610, 4, 1, 0, 2,
              outs_t'{alu_src_a:1'b1, alu_ctrl:4'b0110, default:'0});
        instr(6'b000000, 6'b100000, 1'b0, 24'h007610, 4, 1, 0, -1, '0);
        instr(6'b000000, 6'b100100, 1'b1, 24'h007610, 4, 1, 0, -1, '0);
        instr(6'b000000, 6'b100101, 1'b0, 24'h007610, 4, 1, 0, -1, '0);
        instr(6'b000000, 6'b101010, 1'b0, 24'h007610, 4, 1, 0, 3,
              outs_t'{rf_we:1'b1, reg_dst:1'b1, instr_done:1'b1, default:'0});
        instr(6'b001000, 6'd0, 1'b0, 24'h009810, 4, 1, 0, 2,
              outs_t'{alu_src_a:1'b1, alu_src_b:2'b10, alu_ctrl:4'b0010, default:'0});
        instr(6'b000100, 6'd0, 1'b1, 24'h000A10, 3, 0, 0, 2,
              outs_t'{pc_we:1'b1, alu_src_a:1'b1, alu_ctrl:4'b0110, pc_src:2'b01,
                      instr_done:1'b1, default:'0});
        instr(6'b000100, 6'd0, 1'b0, 24'h000A10, 3, 0, 0, 2,
              outs_t'{alu_src_a:1'b1, alu_ctrl:4'b0110, pc_src:2'b01,
                      instr_done:1'b1, default:'0});
        instr(6'b101011, 6'd0, 1'b0, 24'h004210, 4, 0, 1, 3,
              outs_t'{i_or_d:1'b1, mem_we:1'b1, instr_done:1'b1, default:'0});
        instr(6'b000010, 6'd0, 1'b1, 24'h000B10, 3, 0, 0, 2,
              outs_t'{pc_we:1'b1, pc_src:2'b10, instr_done:1'b1, default:'0});
        instr(6'b111111, 6'd0, 1'b0, 24'h000010, 2, 0, 0, 1,
              outs_t'{alu_src_b:2'b11, alu_ctrl:4'b0010, illegal:1'b1,
                      instr_done:1'b1, default:'0});
        instr(6'b000000, 6'b000000, 1'b0, 24'h000010, 2, 0, 0, 0,
              outs_t'{pc_we:1'b1, ir_we:1'b1, alu_src_b:2'b01, alu_ctrl:4'b0010, default:'0});
        instr(6'b100011, 6'd0, 1'b0, 24'h053210, 5, 1, 0, 2,
              outs_t'{alu_src_a:1'b1, alu_src_b:2'b10, alu_ctrl:4'b0010, default:'0});

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
